// File: rtl/layer_update_scheduler.sv
// rtl/layer_update_scheduler.sv - backprop weight-update sequencer, last layer down to layer 0
// Optional watchdog enabled by defining LAYER_SCHED_TIMEOUT_EN.
module layer_update_scheduler #(
  parameter int LAYER_ADDR_WIDTH = 2,
  parameter int LAYER_MAX        = 4,
  parameter int TIMEOUT_CYCLES   = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [LAYER_ADDR_WIDTH:0] layer_count,
  output logic                      mem_req,
  output logic [LAYER_ADDR_WIDTH-1:0] mem_layer,
  input  logic                      mem_ack,
  output logic                      wc_start,
  output logic [LAYER_ADDR_WIDTH-1:0] wc_layer,
  input  logic                      wc_valid,
  output logic                      busy,
  output logic                      done,
  output logic                      error
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_NEXT  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [LAYER_ADDR_WIDTH:0]   LMAX = (LAYER_ADDR_WIDTH+1)'(LAYER_MAX);
  localparam logic [LAYER_ADDR_WIDTH-1:0] ONE  = LAYER_ADDR_WIDTH'(1);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t                      state;
  logic [LAYER_ADDR_WIDTH-1:0] cur;
  logic [LAYER_ADDR_WIDTH:0]   cnt;
  logic                        timeout;

  // Layer count clamped to the number of physical layers.
  always_comb begin
    cnt = (layer_count > LMAX) ? LMAX : layer_count;
  end

`ifdef LAYER_SCHED_TIMEOUT_EN
  localparam int            TW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tcnt;
  logic          err_q;

  // FETCH and WAIT are never entered from each other, so clearing outside them restarts the count on entry.
  always_ff @(posedge clk) begin
    if (rst || !(state == S_FETCH || state == S_WAIT)) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + TW'(1);
    end
  end

  assign timeout = (state == S_FETCH || state == S_WAIT) && (tcnt == TLIM);

  // Sticky watchdog flag, cleared by reset or the next accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (state == S_IDLE && start) begin
      err_q <= 1'b0;
    end else if (timeout) begin
      err_q <= 1'b1;
    end
  end

  assign error = err_q;
`else
  assign timeout = 1'b0;
  assign error   = 1'b0;
`endif

  // Sequencing FSM; every output is registered together with the state it decodes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cur       <= '0;
      mem_req   <= 1'b0;
      mem_layer <= '0;
      wc_start  <= 1'b0;
      wc_layer  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      wc_start <= 1'b0;
      done     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (cnt == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              cur       <= cnt[LAYER_ADDR_WIDTH-1:0] - ONE;
              mem_layer <= cnt[LAYER_ADDR_WIDTH-1:0] - ONE;
              mem_req   <= 1'b1;
              busy      <= 1'b1;
              state     <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          if (mem_ack) begin
            mem_req  <= 1'b0;
            wc_start <= 1'b1;
            wc_layer <= cur;
            state    <= S_START;
          end else if (timeout) begin
            mem_req <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= S_DONE;
          end
        end
        S_START: begin
          // A valid seen here belongs to the previous layer and is dropped.
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (wc_valid) begin
            state <= S_NEXT;
          end else if (timeout) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_NEXT: begin
          if (cur == '0) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            cur       <= cur - ONE;
            mem_layer <= cur - ONE;
            mem_req   <= 1'b1;
            state     <= S_FETCH;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          mem_req <= 1'b0;
          busy    <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/layer_update_scheduler.md
# layer_update_scheduler

Sequences the backpropagation weight update across all layers of the multiplexed network. On a single `start`, it walks layers from the last down to layer 0. For each layer it requests that layer's z/delta vectors from the activation/delta store, pulses `start` into the weight controller with the layer address, and waits for the controller's `valid`. It sits between the top-level training FSM and the weight controller. It owns no datapath, only handshakes and layer sequencing.

## Interface
- `LAYER_ADDR_WIDTH`, default 2: width of layer addresses.
- `LAYER_MAX`, default 4: maximum number of layers; `layer_count` above this is clamped to `LAYER_MAX`.
- `TIMEOUT_CYCLES`, default 1024: watchdog limit, used only when `LAYER_SCHED_TIMEOUT_EN` is defined.
- `clk`, input, 1: single clock; all logic is on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: one-cycle request to run a full update pass.
- `layer_count`, input, `LAYER_ADDR_WIDTH+1`: number of layers to update; sampled only when `start` is accepted.
- `mem_req`, output, 1: request that z/delta for `mem_layer` be presented to the weight controller.
- `mem_layer`, output, `LAYER_ADDR_WIDTH`: layer whose vectors are requested.
- `mem_ack`, input, 1: the vectors for `mem_layer` are stable on the weight controller inputs.
- `wc_start`, output, 1: one-cycle start pulse to the weight controller.
- `wc_layer`, output, `LAYER_ADDR_WIDTH`: layer address to the weight controller; stable from `wc_start` until `wc_valid`.
- `wc_valid`, input, 1: the weight controller has finished the current layer.
- `busy`, output, 1: a pass is in progress.
- `done`, output, 1: one-cycle pulse when the pass completes.
- `error`, output, 1: sticky watchdog flag; tied to 0 without the macro.

## Operation
- **States:** IDLE, FETCH, START, WAIT, NEXT, DONE, encoded in 3 bits.
- **IDLE:**
  - `start`=1 latches `cnt = min(layer_count, LAYER_MAX)`.
  - If `cnt`=0 → DONE.
  - Otherwise set `cur = cnt-1` and go to FETCH.
  - `start` in any other state is ignored and not queued.
- **FETCH:**
  - `mem_req`=1 and `mem_layer`=`cur`. This is a level request, held until `mem_ack` is sampled high.
  - On `mem_ack` → START.
  - If `mem_ack` is already high on the first FETCH cycle, it is accepted in that cycle.
- **START:** `wc_start`=1 and `wc_layer`=`cur` for exactly one cycle, then → WAIT.
- **WAIT:**
  - On `wc_valid` → NEXT.
  - `wc_valid` in the START cycle is stale and ignored.
- **NEXT:**
  - If `cur`=0 → DONE.
  - Otherwise `cur` decrements by 1 (no wrap below 0) → FETCH.
- **DONE:** `done`=1 for one cycle, `busy`=0 in that cycle, then → IDLE. A `start` during DONE is ignored.
- **`busy`:** 1 in FETCH, START, WAIT and NEXT.
- **Output encoding:** all outputs are registered decodes of state. `wc_layer` and `mem_layer` hold the last value while in IDLE.

## Timing
- **Reset:** `rst` at any edge forces IDLE, `cur`=0, `cnt`=0, and zero on `mem_req`, `mem_layer`, `wc_start`, `wc_layer`, `busy`, `done` and `error`. This applies mid-pass as well. There is no pending `wc_start` after reset.
- **Start acceptance:** `start` sampled at edge k → `busy`=1 and `mem_req`=1 from cycle k+1.
- **Fetch to start:** `mem_ack` sampled at edge m → `mem_req`=0 and `wc_start`=1 in cycle m+1.
- **Layer to layer:** `wc_valid` sampled at edge v → NEXT in cycle v+1 → `mem_req` for the next layer in cycle v+2.
- **Last layer:** `done` in cycle v+2 instead.
- **Per-layer overhead:** 4 cycles, plus the memory and controller latency.
- **Zero layers:** `layer_count`=0 → `done` at k+1, with no `mem_req` and no `wc_start`.

## Configuration
- `LAYER_SCHED_TIMEOUT_EN` defined:
  - A counter resets on every state entry and counts cycles in FETCH and WAIT.
  - Reaching `TIMEOUT_CYCLES` sets `error`=1 (sticky) and forces DONE, which emits `done`.
  - `error` clears on the next accepted `start` or on `rst`.
- `LAYER_SCHED_TIMEOUT_EN` undefined:
  - No counter; FETCH and WAIT wait indefinitely.
  - `error` is constant 0.

## Test plan
- **Full pass:** `layer_count`=3, `mem_ack` 2 cycles after each `mem_req`, `wc_valid` 10 cycles after each `wc_start` → `wc_layer` sequence 2,1,0; exactly 3 `wc_start` pulses; one `done`; `busy` high from k+1 until `done`.
- **Zero and clamp:** `layer_count`=0 → `done` at k+1, no `wc_start`. `layer_count`=7 with `LAYER_MAX`=4 → layers 3,2,1,0.
- **Handshake edges:**
  - `mem_ack` held high constantly → `wc_start` one cycle after each FETCH entry.
  - `wc_valid` high during the START cycle → ignored; the bench asserts no premature NEXT.
- **Ignored and mid-pass inputs:**
  - `start` re-pulsed during WAIT of layer 1 → sequence unchanged, single `done`.
  - `rst` during WAIT of layer 2 → all outputs 0 next cycle; a new `start` restarts from the top layer.
- **Watchdog:** with `LAYER_SCHED_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16, withhold `wc_valid` → `error`=1 and `done` pulse 16 cycles into WAIT; the next `start` clears `error`.
